conv_sysarr_mac_accum: RTL and testbench

- Downstream companion of the systolic-array 6x18 unsigned pipelined multiplier. The multiplier is a 3-register DSP pipeline gated by ce, with no valid tracking of its own.
- This block:
  - accepts operand pairs over a valid/ready handshake;
  - drives the multiplier's din0/din1/ce;
  - carries valid and last flags down a delay line matched to the multiplier;
  - accumulates the returned 24-bit products into a partial sum;
  - emits one psum per last-tagged group over a valid/ready output.

---
 rtl/conv_sysarr_mac_accum.sv | 85 ++++++++
 tb/tb_conv_sysarr_mac_accum.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_sysarr_mac_accum.sv
// Accumulator behind the 6x18 systolic-array multiplier. It feeds operands to the
// multiplier, tracks valid/last alongside its pipeline, and emits one psum per group.
module conv_sysarr_mac_accum #(
  parameter int unsigned A_W     = 6,
  parameter int unsigned B_W     = 18,
  parameter int unsigned P_W     = 24,
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned ACC_W   = 32,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [A_W-1:0]   in_a,
  input  logic [B_W-1:0]   in_b,
  input  logic             in_last,
  output logic             mul_ce,
  output logic [A_W-1:0]   mul_din0,
  output logic [B_W-1:0]   mul_din1,
  input  logic [P_W-1:0]   mul_dout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_psum,
  output logic [CNT_W-1:0] out_cnt
);

  logic [MUL_LAT-1:0] vld_pipe;
  logic [MUL_LAT-1:0] last_pipe;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   sum;
  logic [CNT_W-1:0]   term_cnt;
  logic [CNT_W-1:0]   cnt;
  logic               stall;
  logic               fire;
  logic               tail_v;
  logic               tail_l;

  // A held psum freezes the multiplier and the delay line together.
  assign stall    = out_valid & ~out_ready;
  assign mul_ce   = ~stall;
  assign in_ready = ~stall;
  assign fire     = in_valid & in_ready;

  assign mul_din0 = in_a;
  assign mul_din1 = in_b;

  assign tail_v = vld_pipe[MUL_LAT-1];
  assign tail_l = last_pipe[MUL_LAT-1];
  assign sum    = acc + ACC_W'(mul_dout);
  assign cnt    = term_cnt + CNT_W'(1);

  // Delay line, accumulator and output register all advance only on mul_ce.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
      acc       <= '0;
      term_cnt  <= '0;
      out_valid <= 1'b0;
      out_psum  <= '0;
      out_cnt   <= '0;
    end else if (mul_ce) begin
      vld_pipe  <= (vld_pipe << 1) | MUL_LAT'(fire);
      last_pipe <= (last_pipe << 1) | MUL_LAT'(in_last & fire);
      // mul_ce high implies out_ready or !out_valid, so the held psum drains here.
      if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (tail_v) begin
        if (tail_l) begin
          out_psum  <= sum;
          out_cnt   <= cnt;
          out_valid <= 1'b1;
          acc       <= '0;
          term_cnt  <= '0;
        end else begin
          acc      <= sum;
          term_cnt <= cnt;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_sysarr_mac_accum.sv
// Scoreboard bench for conv_sysarr_mac_accum: 32-bit and 24-bit accumulator instances
// share one behavioural 3-stage multiplier and identical stimulus.
module tb_conv_sysarr_mac_accum;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [5:0]  in_a;
  logic [17:0] in_b;
  logic        in_last;
  logic        out_ready;
  logic        in_ready, in_ready24;
  logic        mul_ce, mul_ce24;
  logic [5:0]  mul_din0, mul_din0_24;
  logic [17:0] mul_din1, mul_din1_24;
  logic [23:0] mul_dout;
  logic        out_valid, out_valid24;
  logic [31:0] out_psum;
  logic [23:0] out_psum24;
  logic [15:0] out_cnt, out_cnt24;

  typedef struct {
    logic [31:0] psum;
    logic [15:0] cnt;
  } exp_t;

  exp_t q32[$];
  exp_t q24[$];
  int   nchk = 0;
  int   nerr = 0;
  int   cyc  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  conv_sysarr_mac_accum u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .mul_ce(mul_ce),
    .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_dout(mul_dout),
    .out_valid(out_valid), .out_ready(out_ready), .out_psum(out_psum), .out_cnt(out_cnt)
  );

  conv_sysarr_mac_accum #(.ACC_W(24)) u_dut24 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready24),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .mul_ce(mul_ce24),
    .mul_din0(mul_din0_24), .mul_din1(mul_din1_24), .mul_dout(mul_dout),
    .out_valid(out_valid24), .out_ready(out_ready), .out_psum(out_psum24), .out_cnt(out_cnt24)
  );

  // Behavioural 3-register multiplier: input regs, product reg, output reg.
  logic [5:0]  m_a;
  logic [17:0] m_b;
  logic [23:0] m_p;
  always @(posedge clk) begin
    if (mul_ce) begin
      m_a      <= mul_din0;
      m_b      <= mul_din1;
      m_p      <= 24'(m_a) * 24'(m_b);
      mul_dout <= m_p;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic [31:0] p32, input logic [23:0] p24, input logic [15:0] c);
    exp_t e;
    e.psum = p32;
    e.cnt  = c;
    q32.push_back(e);
    e.psum = {8'h00, p24};
    q24.push_back(e);
  endtask

  // Present one operand pair and hold it until accepted; returns at accept edge + 1.
  task automatic send(input logic [5:0] a, input logic [17:0] b, input logic last);
    bit ok;
    int guard;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    ok       = 1'b0;
    guard    = 0;
    while (!ok && guard < 200) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!ok) check("send_timeout", 64'd1, 64'd0);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while ((q32.size() != 0 || q24.size() != 0 || out_valid) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("drain_timeout", 64'(guard >= 100), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int at_cyc);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!out_valid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("valid_timeout", 64'(guard >= 50), 64'd0);
    at_cyc = cyc;
  endtask

  // Monitor: compare every psum transferred out of either instance against its queue.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      if (q32.size() == 0) check("unexpected_psum32", 64'(out_psum), 64'hFFFF_FFFF_FFFF_FFFF);
      else begin
        e = q32.pop_front();
        check("psum32", 64'(out_psum), 64'(e.psum));
        check("cnt32", 64'(out_cnt), 64'(e.cnt));
      end
    end
    if (!reset && out_valid24 && out_ready) begin
      if (q24.size() == 0) check("unexpected_psum24", 64'(out_psum24), 64'hFFFF_FFFF_FFFF_FFFF);
      else begin
        e = q24.pop_front();
        check("psum24", 64'(out_psum24), 64'(e.psum));
        check("cnt24", 64'(out_cnt24), 64'(e.cnt));
      end
    end
  end

  int  acc_cyc, rise_cyc;
  bit  bdone;

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_psum", 64'(out_psum), 64'd0);
    check("rst_out_cnt", 64'(out_cnt), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_mul_ce", 64'(mul_ce), 64'd1);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Basic group: 4 x (3*1000) with latency check.
    push_exp(32'd12000, 24'd12000, 16'd4);
    send(6'd3, 18'd1000, 1'b0);
    send(6'd3, 18'd1000, 1'b0);
    send(6'd3, 18'd1000, 1'b0);
    send(6'd3, 18'd1000, 1'b1);
    acc_cyc = cyc;
    wait_valid(rise_cyc);
    check("latency_edges", 64'(rise_cyc - acc_cyc + 1), 64'd4);
    @(negedge clk);
    check("single_pulse", 64'(out_valid), 64'd0);
    wait_drain();

    // Back-to-back groups; second last reaches the tail as the first psum drains.
    push_exp(32'd73, 24'd73, 16'd2);
    push_exp(32'd16515009, 24'd16515009, 16'd1);
    send(6'd2, 18'd5, 1'b0);
    send(6'd7, 18'd9, 1'b1);
    send(6'd63, 18'd262143, 1'b1);
    wait_valid(rise_cyc);
    check("b2b_first_psum", 64'(out_psum), 64'd73);
    @(negedge clk);
    check("b2b_valid_held", 64'(out_valid), 64'd1);
    check("b2b_second_psum", 64'(out_psum), 64'd16515009);
    wait_drain();

    // Backpressure: psum 12000 held while a 3-term group is in flight / queued.
    out_ready = 1'b0;
    push_exp(32'd12000, 24'd12000, 16'd4);
    push_exp(32'd6000, 24'd6000, 16'd3);
    send(6'd3, 18'd1000, 1'b0);
    send(6'd3, 18'd1000, 1'b0);
    send(6'd3, 18'd1000, 1'b0);
    send(6'd3, 18'd1000, 1'b1);
    bdone = 1'b0;
    fork
      begin
        send(6'd10, 18'd100, 1'b0);
        send(6'd20, 18'd100, 1'b0);
        send(6'd30, 18'd100, 1'b1);
        bdone = 1'b1;
      end
    join_none
    repeat (10) @(negedge clk);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    check("bp_mul_ce", 64'(mul_ce), 64'd0);
    check("bp_mul_ce24", 64'(mul_ce24), 64'd0);
    check("bp_out_valid", 64'(out_valid), 64'd1);
    check("bp_psum_held", 64'(out_psum), 64'd12000);
    repeat (3) @(negedge clk);
    check("bp_psum_stable", 64'(out_psum), 64'd12000);
    check("bp_cnt_stable", 64'(out_cnt), 64'd4);
    @(posedge clk);
    #1 out_ready = 1'b1;
    for (int i = 0; i < 100 && !bdone; i++) @(posedge clk);
    check("bp_send_done", 64'(bdone), 64'd1);
    #1;
    wait_drain();

    // Wrap: 2 x 16515009 = 0x1F7FF82; the 24-bit instance keeps 0xF7FF82.
    push_exp(32'h01F7FF82, 24'hF7FF82, 16'd2);
    send(6'd63, 18'd262143, 1'b0);
    send(6'd63, 18'd262143, 1'b1);
    wait_drain();

    // Async reset in the middle of a 4-term group after 2 terms.
    send(6'd5, 18'd5, 1'b0);
    send(6'd5, 18'd5, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_out_psum", 64'(out_psum), 64'd0);
    check("mid_rst_out_cnt", 64'(out_cnt), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 reset = 1'b0;
    push_exp(32'd1, 24'd1, 16'd1);
    send(6'd1, 18'd1, 1'b1);
    wait_valid(rise_cyc);
    check("post_rst_psum", 64'(out_psum), 64'd1);
    check("post_rst_cnt", 64'(out_cnt), 64'd1);
    wait_drain();

    repeat (5) @(negedge clk);
    check("q32_empty", 64'(q32.size()), 64'd0);
    check("q24_empty", 64'(q24.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
